// File: rtl/mining_pkg.sv
// Shared definitions for the golden-nonce reporting path: frame constants,
// reporter FSM encoding and the frame checksum.
package mining_pkg;

   // Every record on the byte stream: header, four nonce bytes, checksum.
   localparam int unsigned FRAME_BYTES = 6;
   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StB3,
      StB2,
      StB1,
      StB0,
      StCsum
   } rep_state_e;

   // XOR of the header and the four nonce bytes, MSB first.
   function automatic logic [7:0] frame_csum(input logic [7:0] hdr, input logic [31:0] nonce);
      return hdr ^ nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
   endfunction

endpackage

// File: rtl/nonce_result_reporter_if.sv
// Hit input and framed byte-stream output of the nonce result reporter.
// master: the environment (miner + consumer); slave: the reporter.
interface nonce_result_reporter_if;

   logic        hit_valid;
   logic [31:0] hit_nonce;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output hit_valid,
      output hit_nonce,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  hit_valid,
      input  hit_nonce,
      input  out_ready,
      output out_data,
      output out_valid
   );

endinterface

// File: rtl/nonce_fifo.sv
// Circular DEPTH x WIDTH FIFO with exact occupancy. Head word is visible on
// rdata_o whenever the FIFO is non-empty. A push while full is only taken
// when a pop happens in the same cycle.
module nonce_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]  level_q, level_d;
   logic             wr_en, rd_en;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LvlW'(DEPTH));
   assign rd_en   = pop_i & ~empty_o;
   assign wr_en   = push_i & (~full_o | rd_en);
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Pointer and level next-state; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/nonce_result_reporter.sv
// Captures golden-nonce hits, drops duplicates of the last accepted nonce,
// buffers them and emits each as a 6-byte frame (header, nonce MSB first,
// checksum) on a valid/ready byte stream. The miner is never stalled:
// hits arriving with no room are dropped and counted.
module nonce_result_reporter
   import mining_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter logic [7:0]  HEADER = HEADER_DEFAULT,
   parameter bit          DEDUP  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nonce_result_reporter_if.slave bus,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [7:0]             drop_count,
   output logic                   busy
);

   rep_state_e state_q, state_d;

   logic [31:0] frame_q, frame_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] last_q, last_d;
   logic        last_valid_q, last_valid_d;
   logic [7:0]  drop_q, drop_d;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0] fifo_rdata;
   logic        out_fire, is_dup, hit_new;

   assign out_fire = bus.out_valid & bus.out_ready;

   // Load a new frame whenever idle, or right as the checksum byte leaves, so
   // queued hits go out back-to-back.
   assign fifo_pop = ((state_q == StIdle) | ((state_q == StCsum) & out_fire)) & ~fifo_empty;

   assign is_dup    = DEDUP & last_valid_q & (bus.hit_nonce == last_q);
   assign hit_new   = bus.hit_valid & ~is_dup;
   // A slot freed by this cycle's pop is usable by this cycle's hit.
   assign fifo_push = hit_new & (~fifo_full | fifo_pop);

   nonce_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (bus.hit_nonce),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // FSM state register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next state: each byte state advances only on an accepted byte.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (fifo_pop) state_d = StHdr;
         StHdr:  if (out_fire) state_d = StB3;
         StB3:   if (out_fire) state_d = StB2;
         StB2:   if (out_fire) state_d = StB1;
         StB1:   if (out_fire) state_d = StB0;
         StB0:   if (out_fire) state_d = StCsum;
         StCsum: if (out_fire) state_d = fifo_pop ? StHdr : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: purely state-decoded so out_valid drops with the async reset.
   always_comb begin
      bus.out_valid = (state_q != StIdle);
      bus.out_data  = 8'h00;
      unique case (state_q)
         StHdr:   bus.out_data = HEADER;
         StB3:    bus.out_data = frame_q[31:24];
         StB2:    bus.out_data = frame_q[23:16];
         StB1:    bus.out_data = frame_q[15:8];
         StB0:    bus.out_data = frame_q[7:0];
         StCsum:  bus.out_data = csum_q;
         default: bus.out_data = 8'h00;
      endcase
   end

   // Frame capture, dedup history and saturating drop counter next state.
   always_comb begin
      frame_d      = frame_q;
      csum_d       = csum_q;
      last_d       = last_q;
      last_valid_d = last_valid_q;
      drop_d       = drop_q;
      if (fifo_pop) begin
         frame_d = fifo_rdata;
         csum_d  = frame_csum(HEADER, fifo_rdata);
      end
      if (fifo_push) begin
         last_d       = bus.hit_nonce;
         last_valid_d = 1'b1;
      end else if (hit_new && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q      <= '0;
         csum_q       <= '0;
         last_q       <= '0;
         last_valid_q <= 1'b0;
         drop_q       <= '0;
      end else begin
         frame_q      <= frame_d;
         csum_q       <= csum_d;
         last_q       <= last_d;
         last_valid_q <= last_valid_d;
         drop_q       <= drop_d;
      end
   end

   assign drop_count = drop_q;
   assign busy       = (state_q != StIdle) | ~fifo_empty;

endmodule
